// File: rtl/drive_cmd_sequencer.sv
// Paces speed-command frames to a downstream serial sender: change requests,
// periodic heartbeat refresh, minimum inter-frame gap and emergency-stop override.
module drive_cmd_sequencer #(
  parameter int unsigned HEARTBEAT_CYCLES = 32'd25_000_000,
  parameter int unsigned MIN_GAP_CYCLES   = 32'd2_500_000,
  parameter int unsigned ACCEPT_TIMEOUT   = 32'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_speed,
  output logic        req_ready,
  input  logic        estop,
  output logic        tx_start,
  output logic [2:0]  tx_speed,
  input  logic        tx_ready,
  output logic [2:0]  active_speed,
  output logic        busy,
  output logic        tx_error,
  output logic [15:0] cmd_count
);

  localparam int HB_W  = (HEARTBEAT_CYCLES > 32'd1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam int GAP_W = (MIN_GAP_CYCLES > 32'd0) ? $clog2(MIN_GAP_CYCLES + 32'd1) : 1;
  localparam int ACC_W = (ACCEPT_TIMEOUT > 32'd1) ? $clog2(ACCEPT_TIMEOUT) : 1;

  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 32'd1);
  localparam logic [HB_W-1:0]  HB_ONE   = HB_W'(32'd1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(32'd1);
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEPT_TIMEOUT - 32'd1);
  localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(32'd1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LAUNCH      = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              pending_r, estop_pend_r, estop_d_r;
  logic [2:0]        pend_speed_r;
  logic [HB_W-1:0]   hb_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic [ACC_W-1:0]  acc_cnt_r;
  logic              tx_start_r, busy_r, tx_error_r;
  logic [2:0]        tx_speed_r, active_speed_r;
  logic [15:0]       cmd_count_r;

  logic              estop_rise_s, gap_done_s, hb_due_s, req_fire_s;
  logic              launch_go_s, timeout_s, done_s;
  logic [2:0]        launch_speed_s;

  assign estop_rise_s   = estop && !estop_d_r;
  assign gap_done_s     = (gap_cnt_r == GAP_MAX);
  assign hb_due_s       = (hb_cnt_r == HB_LAST);
  assign req_fire_s     = req_valid && !pending_r;
  assign launch_go_s    = (state_r == IDLE) && (state_s == LAUNCH);
  assign launch_speed_s = pending_r ? pend_speed_r : active_speed_r;

  // Next-state decode; an estop-originated pending frame skips the gap wait
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_ready && ((pending_r && gap_done_s) || (hb_due_s && gap_done_s) ||
                         (pending_r && estop_pend_r))) begin
          state_s = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: state_s = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        if (!tx_ready) begin
          state_s = WAIT_DONE;
        end else if (acc_cnt_r == ACC_LAST) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = WAIT_ACCEPT;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, request capture, timers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      pending_r      <= 1'b1;
      pend_speed_r   <= 3'd0;
      estop_pend_r   <= 1'b0;
      estop_d_r      <= 1'b0;
      hb_cnt_r       <= '0;
      gap_cnt_r      <= GAP_MAX;
      acc_cnt_r      <= '0;
      tx_start_r     <= 1'b0;
      tx_speed_r     <= 3'd0;
      active_speed_r <= 3'd0;
      busy_r         <= 1'b0;
      tx_error_r     <= 1'b0;
      cmd_count_r    <= 16'd0;
    end else begin
      state_r   <= state_s;
      estop_d_r <= estop;
      busy_r    <= (state_s != IDLE);
      tx_start_r <= launch_go_s;

      // Estop edge wins over a same-cycle request; a new request wins over launch clear
      if (estop_rise_s) begin
        pending_r    <= 1'b1;
        pend_speed_r <= 3'd0;
        estop_pend_r <= 1'b1;
      end else if (req_fire_s && !estop && (req_speed != active_speed_r)) begin
        pending_r    <= 1'b1;
        pend_speed_r <= req_speed;
        estop_pend_r <= 1'b0;
      end else if (launch_go_s) begin
        pending_r    <= 1'b0;
        estop_pend_r <= 1'b0;
      end

      if (launch_go_s) begin
        tx_speed_r     <= launch_speed_s;
        active_speed_r <= launch_speed_s;
        hb_cnt_r       <= '0;
        acc_cnt_r      <= '0;
      end else begin
        if ((state_r == IDLE) && !hb_due_s) hb_cnt_r <= hb_cnt_r + HB_ONE;
        if ((state_r == WAIT_ACCEPT) && tx_ready && (acc_cnt_r != ACC_LAST))
          acc_cnt_r <= acc_cnt_r + ACC_ONE;
      end

      if (timeout_s || done_s) begin
        gap_cnt_r <= '0;
      end else if ((state_r == IDLE) && !gap_done_s) begin
        gap_cnt_r <= gap_cnt_r + GAP_ONE;
      end

      if (timeout_s) tx_error_r <= 1'b1;
      if (done_s) cmd_count_r <= cmd_count_r + 16'd1;
    end
  end

  assign req_ready    = !pending_r;
  assign tx_start     = tx_start_r;
  assign tx_speed     = tx_speed_r;
  assign active_speed = active_speed_r;
  assign busy         = busy_r;
  assign tx_error     = tx_error_r;
  assign cmd_count    = cmd_count_r;

endmodule
